tdc_enable_reg: RTL and testbench
=================================

TDC_ENABLE_REG -- requirements
Module: tdc_enable_reg

Interface
REQ-001 The module SHALL have parameter MASK_WIDTH, default 16: the number of per-channel enable bits; the register is MASK_WIDTH+1 bits wide and its MSB is the master switch.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 1024: the maximum number of cycles spent in NOTIFY before abort (used only with TDC_ENREG_TIMEOUT_EN).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port wr_en, input, 1 bit: host write strobe, one cycle per write.
REQ-006 The module SHALL have port wr_data, input, MASK_WIDTH+1 bits: host write value.
REQ-007 The module SHALL have port rd_data, output, MASK_WIDTH+1 bits: host readback of the most recently written value (shadow).
REQ-008 The module SHALL have port activate_channels, output, MASK_WIDTH+1 bits: snapshot presented to the channel-enable consumer.
REQ-009 The module SHALL have port channel_changed, output, 1 bit: level request to the consumer to read the snapshot.
REQ-010 The module SHALL have port read_active_channel, input, 1 bit: the consumer's read request, held high until read_ack is seen.
REQ-011 The module SHALL have port read_ack, output, 1 bit: single-cycle acknowledge; the consumer latches activate_channels on this cycle.
REQ-012 The module SHALL have port timeout_err, output, 1 bit: sticky abort flag.

Function
REQ-013 The module SHALL register every output; there SHALL be no combinational path from an input to an output.
REQ-014 The FSM SHALL have states IDLE, NOTIFY, ACK and GAP.
REQ-015 In IDLE, a write (wr_en=1) SHALL load both shadow and snapshot with wr_data and move the FSM to NOTIFY on the next edge.
REQ-016 channel_changed SHALL be 1 in NOTIFY and 0 in every other state.
REQ-017 In NOTIFY with read_active_channel=0, a write SHALL update shadow and snapshot directly (writes coalesce) and the FSM SHALL stay in NOTIFY.
REQ-018 In NOTIFY with read_active_channel=1, the FSM SHALL move to ACK; from that edge until ACK is left, snapshot SHALL be frozen.
REQ-019 ACK SHALL last exactly one cycle: read_ack=1 and channel_changed=0 in that cycle, then the FSM SHALL move to GAP.
REQ-020 GAP SHALL last one cycle with read_ack=0, so the consumer can drop read_active_channel before any new request.
REQ-021 A write during ACK or GAP SHALL update shadow only and set a pending flag.
REQ-022 On leaving GAP with pending=1, the module SHALL copy shadow to snapshot, clear pending and enter NOTIFY; otherwise it SHALL enter IDLE.
REQ-023 A write that coincides with the GAP exit SHALL be included: that wr_data SHALL be the copied value.
REQ-024 read_ack SHALL never be asserted outside ACK, including when read_active_channel is high while channel_changed=0.
REQ-025 rd_data SHALL equal shadow, updated one cycle after wr_en.
REQ-026 End-to-end latency SHALL be: write in IDLE at cycle N gives channel_changed=1 at N+1.

Reset
REQ-027 While reset=1, the module SHALL return to IDLE and clear shadow, snapshot, pending, the timeout counter, channel_changed, read_ack and timeout_err to 0.
REQ-028 Reset SHALL take priority over wr_en and over any state, including mid-handshake; any in-flight request SHALL be dropped without read_ack.

Configuration
REQ-029 With macro TDC_ENREG_TIMEOUT_EN defined, a counter SHALL clear on entry to NOTIFY and increment each NOTIFY cycle.
REQ-030 With TDC_ENREG_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without read_active_channel SHALL set timeout_err, return the FSM to IDLE and keep shadow; timeout_err SHALL clear on the next wr_en.
REQ-031 Without TDC_ENREG_TIMEOUT_EN, NOTIFY SHALL wait indefinitely, timeout_err SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-032 The bench SHALL cover: write 0x00003 in IDLE -> channel_changed=1 next cycle; with read_active_channel asserted, read_ack pulses one cycle with activate_channels=0x00003.
REQ-033 The bench SHALL cover: writes 0x00001 then 0x00002 in NOTIFY before read_active_channel -> a single handshake with activate_channels=0x00002.
REQ-034 The bench SHALL cover: write 0x10000 during ACK -> activate_channels=old value at ack, then after GAP channel_changed=1 again with 0x10000; rd_data=0x10000.
REQ-035 The bench SHALL cover: read_active_channel held high for 3 cycles after ack -> exactly one read_ack pulse.
REQ-036 The bench SHALL cover: reset asserted in NOTIFY -> next cycle all outputs 0, state IDLE, no read_ack.
REQ-037 The bench SHALL cover, with TDC_ENREG_TIMEOUT_EN and TIMEOUT_CYCLES=8: no read for 8 cycles -> timeout_err=1, channel_changed=0; next write clears timeout_err.

Source files
------------

// File: rtl/tdc_enable_reg.sv
// Channel-enable register with a shadow/snapshot handshake toward the channel-enable consumer.
// Optional NOTIFY abort on timeout is enabled by defining TDC_ENREG_TIMEOUT_EN.
module tdc_enable_reg #(
  parameter int unsigned MASK_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [MASK_WIDTH:0]   wr_data,
  output logic [MASK_WIDTH:0]   rd_data,
  output logic [MASK_WIDTH:0]   activate_channels,
  output logic                  channel_changed,
  input  logic                  read_active_channel,
  output logic                  read_ack,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, NOTIFY, ACK, GAP} state_t;

  state_t                state;
  logic [MASK_WIDTH:0]   shadow;
  logic [MASK_WIDTH:0]   snapshot;
  logic                  pending;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef TDC_ENREG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  assign rd_data           = shadow;
  assign activate_channels = snapshot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      shadow          <= '0;
      snapshot        <= '0;
      pending         <= 1'b0;
      channel_changed <= 1'b0;
      read_ack        <= 1'b0;
`ifdef TDC_ENREG_TIMEOUT_EN
      cnt             <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        shadow <= wr_data;
`ifdef TDC_ENREG_TIMEOUT_EN
        timeout_err <= 1'b0;
`endif
      end

      unique case (state)
        IDLE: begin
          if (wr_en) begin
            snapshot        <= wr_data;
            state           <= NOTIFY;
            channel_changed <= 1'b1;
`ifdef TDC_ENREG_TIMEOUT_EN
            cnt             <= '0;
`endif
          end
        end

        NOTIFY: begin
          if (read_active_channel) begin
            // Snapshot freezes from here; a same-cycle write waits in shadow.
            state           <= ACK;
            channel_changed <= 1'b0;
            read_ack        <= 1'b1;
            if (wr_en) pending <= 1'b1;
          end
`ifdef TDC_ENREG_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            channel_changed <= 1'b0;
            timeout_err     <= 1'b1;
          end
`endif
          else begin
            if (wr_en) snapshot <= wr_data;
`ifdef TDC_ENREG_TIMEOUT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end

        ACK: begin
          read_ack <= 1'b0;
          state    <= GAP;
          if (wr_en) pending <= 1'b1;
        end

        GAP: begin
          if (pending || wr_en) begin
            // A write on the exit edge bypasses shadow so its data is the one published.
            snapshot        <= wr_en ? wr_data : shadow;
            pending         <= 1'b0;
            state           <= NOTIFY;
            channel_changed <= 1'b1;
`ifdef TDC_ENREG_TIMEOUT_EN
            cnt             <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state           <= IDLE;
          channel_changed <= 1'b0;
          read_ack        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_enable_reg.sv
// Directed table-driven bench for tdc_enable_reg; the timeout sequence runs when
// TDC_ENREG_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=8).
module tb_tdc_enable_reg;

  localparam int unsigned MW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [MW:0]   wr_data;
  logic [MW:0]   rd_data;
  logic [MW:0]   activate_channels;
  logic          channel_changed;
  logic          read_active_channel;
  logic          read_ack;
  logic          timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  tdc_enable_reg #(
    .MASK_WIDTH     (MW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .wr_en               (wr_en),
    .wr_data             (wr_data),
    .rd_data             (rd_data),
    .activate_channels   (activate_channels),
    .channel_changed     (channel_changed),
    .read_active_channel (read_active_channel),
    .read_ack            (read_ack),
    .timeout_err         (timeout_err)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [MW:0] wd;
    logic        rac;
    logic        exp_cc;
    logic        exp_ack;
    logic [MW:0] exp_act;
    logic [MW:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [MW:0] wd, input logic rac);
    reset = rst; wr_en = we; wr_data = wd; read_active_channel = rac;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic we, input logic [MW:0] wd, input logic rac,
                     input logic cc, input logic ack, input logic [MW:0] act, input logic [MW:0] rd);
    vecs.push_back('{rst, we, wd, rac, cc, ack, act, rd});
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; read_active_channel = 1'b0;

    //   rst we  wd        rac  cc ack act       rd
    add(1, 0, 17'h00000, 0,   0, 0, 17'h00000, 17'h00000); // 0  reset state
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00000, 17'h00000); // 1  idle
    add(0, 1, 17'h00003, 0,   1, 0, 17'h00003, 17'h00003); // 2  write in IDLE -> notify
    add(0, 0, 17'h00000, 1,   0, 1, 17'h00003, 17'h00003); // 3  ack
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00003, 17'h00003); // 4  gap
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00003, 17'h00003); // 5  idle
    add(0, 1, 17'h00001, 0,   1, 0, 17'h00001, 17'h00001); // 6  write 1
    add(0, 1, 17'h00002, 0,   1, 0, 17'h00002, 17'h00002); // 7  coalesced write 2
    add(0, 0, 17'h00000, 1,   0, 1, 17'h00002, 17'h00002); // 8  single ack with 2
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00002, 17'h00002); // 9  gap
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00002, 17'h00002); // 10 idle
    add(0, 1, 17'h00005, 0,   1, 0, 17'h00005, 17'h00005); // 11 write 5
    add(0, 0, 17'h00000, 1,   0, 1, 17'h00005, 17'h00005); // 12 ack
    add(0, 0, 17'h00000, 1,   0, 0, 17'h00005, 17'h00005); // 13 rac held: gap
    add(0, 0, 17'h00000, 1,   0, 0, 17'h00005, 17'h00005); // 14 rac held: idle
    add(0, 0, 17'h00000, 1,   0, 0, 17'h00005, 17'h00005); // 15 rac held: no ack
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00005, 17'h00005); // 16
    add(0, 1, 17'h00007, 0,   1, 0, 17'h00007, 17'h00007); // 17 write 7
    add(0, 0, 17'h00000, 1,   0, 1, 17'h00007, 17'h00007); // 18 ack with 7
    add(0, 1, 17'h10000, 0,   0, 0, 17'h00007, 17'h10000); // 19 write during ACK: shadow only
    add(0, 0, 17'h00000, 0,   1, 0, 17'h10000, 17'h10000); // 20 pending -> notify again
    add(0, 0, 17'h00000, 1,   0, 1, 17'h10000, 17'h10000); // 21 ack with 0x10000
    add(0, 0, 17'h00000, 0,   0, 0, 17'h10000, 17'h10000); // 22 gap
    add(0, 0, 17'h00000, 0,   0, 0, 17'h10000, 17'h10000); // 23 idle
    add(0, 1, 17'h00009, 0,   1, 0, 17'h00009, 17'h00009); // 24 write 9
    add(0, 0, 17'h00000, 1,   0, 1, 17'h00009, 17'h00009); // 25 ack
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00009, 17'h00009); // 26 gap
    add(0, 1, 17'h00011, 0,   1, 0, 17'h00011, 17'h00011); // 27 write on GAP exit included
    add(1, 1, 17'h1FFFF, 1,   0, 0, 17'h00000, 17'h00000); // 28 reset in NOTIFY wins
    add(0, 0, 17'h00000, 0,   0, 0, 17'h00000, 17'h00000); // 29 idle after reset
    add(0, 0, 17'h00000, 1,   0, 0, 17'h00000, 17'h00000); // 30 rac in IDLE: no ack
    add(0, 1, 17'h1FFFF, 0,   1, 0, 17'h1FFFF, 17'h1FFFF); // 31 all-ones write
    add(0, 0, 17'h00000, 1,   0, 1, 17'h1FFFF, 17'h1FFFF); // 32 ack
    add(0, 0, 17'h00000, 0,   0, 0, 17'h1FFFF, 17'h1FFFF); // 33 gap
    add(0, 0, 17'h00000, 0,   0, 0, 17'h1FFFF, 17'h1FFFF); // 34 idle

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].rac);
      chk($sformatf("v%0d channel_changed", i), 32'(channel_changed), 32'(vecs[i].exp_cc));
      chk($sformatf("v%0d read_ack", i), 32'(read_ack), 32'(vecs[i].exp_ack));
      chk($sformatf("v%0d activate_channels", i), 32'(activate_channels), 32'(vecs[i].exp_act));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'd0);
    end

    // Read ack must be a one-cycle pulse under a long-held request.
    begin
      int unsigned acks = 0;
      drive(0, 1, 17'h00042, 0);
      for (int i = 0; i < 5; i++) begin
        drive(0, 0, 17'h00000, 1);
        if (read_ack) acks++;
      end
      chk("held_rac ack_count", 32'(acks), 32'd1);
      drive(0, 0, 17'h00000, 0);
      chk("held_rac idle channel_changed", 32'(channel_changed), 32'd0);
    end

`ifdef TDC_ENREG_TIMEOUT_EN
    drive(0, 1, 17'h00042, 0);
    chk("to notify channel_changed", 32'(channel_changed), 32'd1);
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 17'h00000, 0);
      chk($sformatf("to wait%0d channel_changed", i), 32'(channel_changed), 32'd1);
      chk($sformatf("to wait%0d timeout_err", i), 32'(timeout_err), 32'd0);
    end
    drive(0, 0, 17'h00000, 0);
    chk("to expire timeout_err", 32'(timeout_err), 32'd1);
    chk("to expire channel_changed", 32'(channel_changed), 32'd0);
    chk("to expire rd_data", 32'(rd_data), 32'h42);
    drive(0, 0, 17'h00000, 1);
    chk("to idle read_ack", 32'(read_ack), 32'd0);
    chk("to sticky timeout_err", 32'(timeout_err), 32'd1);
    drive(0, 1, 17'h00003, 0);
    chk("to clear timeout_err", 32'(timeout_err), 32'd0);
    chk("to clear channel_changed", 32'(channel_changed), 32'd1);
    drive(0, 0, 17'h00000, 1);
    chk("to clear read_ack", 32'(read_ack), 32'd1);
    drive(0, 0, 17'h00000, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
